centroid_update: RTL and testbench

CENTROID_UPDATE -- requirements
Module: centroid_update

---
 rtl/centroid_update_if.sv | 31 +++
 rtl/centroid_update.sv | 173 +++++++++++++++++
 tb/tb_centroid_update.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/centroid_update_if.sv
// Bus between the assignment stage and the centroid update engine: the
// start/busy/done handshake plus the point, assignment and centre arrays.
interface centroid_update_if #(
    parameter int WIDTH        = 32,
    parameter int NUM_CLUSTERS = 8,
    parameter int NUM_POINTS   = 128
);
    localparam int AW = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;

    logic             start;
    logic [WIDTH-1:0] points_x      [NUM_POINTS];
    logic [WIDTH-1:0] points_y      [NUM_POINTS];
    logic [AW-1:0]    assignments   [NUM_POINTS];
    logic [WIDTH-1:0] old_centers_x [NUM_CLUSTERS];
    logic [WIDTH-1:0] old_centers_y [NUM_CLUSTERS];
    logic [WIDTH-1:0] new_centers_x [NUM_CLUSTERS];
    logic [WIDTH-1:0] new_centers_y [NUM_CLUSTERS];
    logic             busy;
    logic             done;
    logic             converged;

    modport master (
        output start, points_x, points_y, assignments, old_centers_x, old_centers_y,
        input  new_centers_x, new_centers_y, busy, done, converged
    );

    modport slave (
        input  start, points_x, points_y, assignments, old_centers_x, old_centers_y,
        output new_centers_x, new_centers_y, busy, done, converged
    );
endinterface

// File: rtl/centroid_update.sv
// K-means centroid update: accumulates per-cluster coordinate sums and
// counts over all points, then divides each cluster's sums by its count
// with a bit-serial restoring divider (X and Y in parallel). Fixed latency.
module centroid_update #(
    parameter int WIDTH        = 32,
    parameter int NUM_CLUSTERS = 8,
    parameter int NUM_POINTS   = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    centroid_update_if.slave  bus
);
    localparam int ACC_W = WIDTH + $clog2(NUM_POINTS);
    localparam int CW    = $clog2(NUM_POINTS + 1);
    localparam int AW    = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
    localparam int PW    = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
    localparam int BW    = $clog2(ACC_W);

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DIVIDE, FINISH} state_t;

    state_t           state_q;
    logic             busy_q, done_q, conv_q;
    logic [PW-1:0]    pt_q;
    logic [AW-1:0]    cl_q;
    logic [BW-1:0]    bit_q;
    logic [ACC_W-1:0] sum_x_q [NUM_CLUSTERS];
    logic [ACC_W-1:0] sum_y_q [NUM_CLUSTERS];
    logic [CW-1:0]    cnt_q   [NUM_CLUSTERS];
    logic [CW-1:0]    rem_x_q, rem_y_q;
    logic [ACC_W-1:0] quo_x_q, quo_y_q;
    logic [WIDTH-1:0] ncx_q   [NUM_CLUSTERS];
    logic [WIDTH-1:0] ncy_q   [NUM_CLUSTERS];

    logic [AW-1:0]    pt_asg;
    logic             pt_valid;
    logic [CW-1:0]    div_cnt, rem_x_base, rem_y_base;
    logic [CW:0]      trial_x, trial_y;
    logic             qbit_x, qbit_y;
    logic [CW-1:0]    rem_x_d, rem_y_d;
    logic [ACC_W-1:0] quo_x_d, quo_y_d;
    logic             conv_d;

    assign pt_asg = bus.assignments[pt_q];

    // Out-of-range assignments can only occur when the cluster count is not a power of two.
    generate
        if ((1 << AW) == NUM_CLUSTERS) begin : g_pow2
            assign pt_valid = 1'b1;
        end else begin : g_npow2
            assign pt_valid = (32'(pt_asg) < 32'(NUM_CLUSTERS));
        end
    endgenerate

    // One restoring-division step, MSB first; remainder starts from zero on a slot's first bit.
    always_comb begin
        div_cnt    = cnt_q[cl_q];
        rem_x_base = (bit_q == BW'(ACC_W - 1)) ? '0 : rem_x_q;
        rem_y_base = (bit_q == BW'(ACC_W - 1)) ? '0 : rem_y_q;
        trial_x    = {rem_x_base, sum_x_q[cl_q][bit_q]};
        trial_y    = {rem_y_base, sum_y_q[cl_q][bit_q]};
        qbit_x     = (trial_x >= {1'b0, div_cnt});
        qbit_y     = (trial_y >= {1'b0, div_cnt});
        rem_x_d    = qbit_x ? CW'(trial_x - {1'b0, div_cnt}) : trial_x[CW-1:0];
        rem_y_d    = qbit_y ? CW'(trial_y - {1'b0, div_cnt}) : trial_y[CW-1:0];
        quo_x_d    = {quo_x_q[ACC_W-2:0], qbit_x};
        quo_y_d    = {quo_y_q[ACC_W-2:0], qbit_y};
    end

    // Convergence: every freshly written centre matches its old centre in both axes.
    always_comb begin
        conv_d = 1'b1;
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            if (ncx_q[c] != bus.old_centers_x[c] || ncy_q[c] != bus.old_centers_y[c]) begin
                conv_d = 1'b0;
            end
        end
    end

    // Control FSM with registered outputs, accumulators and divider state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            pt_q    <= '0;
            cl_q    <= '0;
            bit_q   <= '0;
            rem_x_q <= '0;
            rem_y_q <= '0;
            quo_x_q <= '0;
            quo_y_q <= '0;
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
                sum_x_q[c] <= '0;
                sum_y_q[c] <= '0;
                cnt_q[c]   <= '0;
                ncx_q[c]   <= '0;
                ncy_q[c]   <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        conv_q  <= 1'b0;
                    end
                end
                CLEAR: begin
                    for (int c = 0; c < NUM_CLUSTERS; c++) begin
                        sum_x_q[c] <= '0;
                        sum_y_q[c] <= '0;
                        cnt_q[c]   <= '0;
                    end
                    pt_q    <= '0;
                    state_q <= ACCUM;
                end
                ACCUM: begin
                    if (pt_valid) begin
                        sum_x_q[pt_asg] <= sum_x_q[pt_asg] + ACC_W'(bus.points_x[pt_q]);
                        sum_y_q[pt_asg] <= sum_y_q[pt_asg] + ACC_W'(bus.points_y[pt_q]);
                        cnt_q[pt_asg]   <= cnt_q[pt_asg] + CW'(1);
                    end
                    if (pt_q == PW'(NUM_POINTS - 1)) begin
                        state_q <= DIVIDE;
                        cl_q    <= '0;
                        bit_q   <= BW'(ACC_W - 1);
                    end else begin
                        pt_q <= pt_q + PW'(1);
                    end
                end
                DIVIDE: begin
                    rem_x_q <= rem_x_d;
                    rem_y_q <= rem_y_d;
                    quo_x_q <= quo_x_d;
                    quo_y_q <= quo_y_d;
                    if (bit_q == '0) begin
                        // Empty clusters keep their old centre instead of dividing by zero.
                        if (div_cnt == '0) begin
                            ncx_q[cl_q] <= bus.old_centers_x[cl_q];
                            ncy_q[cl_q] <= bus.old_centers_y[cl_q];
                        end else begin
                            ncx_q[cl_q] <= quo_x_d[WIDTH-1:0];
                            ncy_q[cl_q] <= quo_y_d[WIDTH-1:0];
                        end
                        bit_q <= BW'(ACC_W - 1);
                        if (cl_q == AW'(NUM_CLUSTERS - 1)) begin
                            state_q <= FINISH;
                        end else begin
                            cl_q <= cl_q + AW'(1);
                        end
                    end else begin
                        bit_q <= bit_q - BW'(1);
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    conv_q  <= conv_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.converged     = conv_q;
    assign bus.new_centers_x = ncx_q;
    assign bus.new_centers_y = ncy_q;
endmodule

// File: tb/tb_centroid_update.sv
// Bench for centroid_update: table of full-update vectors plus hand-written
// reset-abort, busy-ignore and back-to-back sequences, scored by a queue.
module tb_centroid_update;
    localparam int W   = 32;
    localparam int NC  = 8;
    localparam int NP  = 128;
    localparam int LAT = 442;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    centroid_update_if #(.WIDTH(W), .NUM_CLUSTERS(NC), .NUM_POINTS(NP)) bus ();

    centroid_update #(.WIDTH(W), .NUM_CLUSTERS(NC), .NUM_POINTS(NP)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] xa, ya;
        int           asga, na;
        bit           ramp;
        logic [W-1:0] xb, yb;
        int           asgb;
        logic [W-1:0] ofx, ofy;
        bit           prev;
        int           ca;
        logic [W-1:0] eax, eay;
        int           cb;
        logic [W-1:0] ebx, eby;
        bit           econv;
    } vec_t;

    typedef struct {
        int                    due;
        logic [NC-1:0][W-1:0]  ex;
        logic [NC-1:0][W-1:0]  ey;
        bit                    conv;
    } exp_t;

    vec_t vt[7];
    exp_t sbq[$];
    exp_t last_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one vector's inputs, queue its expected result, pulse start for one edge.
    task automatic launch(input int i);
        vec_t v;
        exp_t e;
        v = vt[i];
        for (int p = 0; p < NP; p++) begin
            if (p < v.na) begin
                bus.points_x[p]    = v.ramp ? v.xa + W'(p) : v.xa;
                bus.points_y[p]    = v.ramp ? v.ya + W'(p) : v.ya;
                bus.assignments[p] = 3'(v.asga);
            end else begin
                bus.points_x[p]    = v.xb;
                bus.points_y[p]    = v.yb;
                bus.assignments[p] = 3'(v.asgb);
            end
        end
        for (int c = 0; c < NC; c++) begin
            bus.old_centers_x[c] = v.prev ? last_exp.ex[c] : v.ofx;
            bus.old_centers_y[c] = v.prev ? last_exp.ey[c] : v.ofy;
            e.ex[c] = bus.old_centers_x[c];
            e.ey[c] = bus.old_centers_y[c];
        end
        e.ex[v.cb] = v.ebx;
        e.ey[v.cb] = v.eby;
        e.ex[v.ca] = v.eax;
        e.ey[v.ca] = v.eay;
        e.conv     = v.econv;
        e.due      = cyc + 1 + LAT;
        last_exp   = e;
        bus.start  = 1'b1;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 600) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d results outstanding, expected 0", tag, sbq.size());
            sbq.delete();
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_latency", 64'(cyc), 64'(e.due));
                chk("converged", 64'(bus.converged), 64'(e.conv));
                chk("busy_at_done", 64'(bus.busy), 64'd0);
                for (int c = 0; c < NC; c++) begin
                    chk($sformatf("new_x[%0d]", c), 64'(bus.new_centers_x[c]), 64'(e.ex[c]));
                    chk($sformatf("new_y[%0d]", c), 64'(bus.new_centers_y[c]), 64'(e.ey[c]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          xa     ya     asga na  ramp xb   yb   asgb ofx ofy prev ca eax    eay    cb ebx  eby  conv
        vt[0] = '{32'd10, 32'd20, 0, 64,  1'b0, 32'd30,  32'd41,  1, 32'd0,  32'd0,  1'b0, 0, 32'd10, 32'd20, 1, 32'd30,  32'd41,  1'b0};
        vt[1] = '{32'd10, 32'd20, 0, 64,  1'b0, 32'd30,  32'd41,  1, 32'd0,  32'd0,  1'b1, 0, 32'd10, 32'd20, 1, 32'd30,  32'd41,  1'b1};
        vt[2] = '{32'd1,  32'd1,  3, 2,   1'b1, 32'd100, 32'd100, 5, 32'd7,  32'd9,  1'b0, 3, 32'd1,  32'd1,  5, 32'd100, 32'd100, 1'b0};
        vt[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 128, 1'b0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 1'b0, 7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vt[4] = '{32'd0,  32'd5,  2, 128, 1'b1, 32'd0,   32'd0,   0, 32'd0,  32'd0,  1'b0, 2, 32'd63, 32'd68, 2, 32'd63,  32'd68,  1'b0};
        vt[5] = '{32'd10, 32'd20, 0, 128, 1'b0, 32'd0,   32'd0,   0, 32'd10, 32'd20, 1'b0, 0, 32'd10, 32'd20, 0, 32'd10,  32'd20,  1'b1};
        vt[6] = '{32'd10, 32'd20, 0, 128, 1'b0, 32'd0,   32'd0,   0, 32'd10, 32'd21, 1'b0, 0, 32'd10, 32'd20, 0, 32'd10,  32'd20,  1'b0};

        bus.start = 1'b0;
        for (int p = 0; p < NP; p++) begin
            bus.points_x[p] = '0;
            bus.points_y[p] = '0;
            bus.assignments[p] = '0;
        end
        for (int c = 0; c < NC; c++) begin
            bus.old_centers_x[c] = '0;
            bus.old_centers_y[c] = '0;
        end

        // Reset state
        #12;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_conv", 64'(bus.converged), 64'd0);
        chk("rst_new_x0", 64'(bus.new_centers_x[0]), 64'd0);
        chk("rst_new_y7", 64'(bus.new_centers_y[7]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven full updates
        for (int i = 0; i < 7; i++) begin
            launch(i);
            wait_idle($sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Reset in the middle of a run aborts it without a done pulse
        launch(0);
        repeat (198) @(negedge clk);
        chk("pre_reset_new_x0", 64'(bus.new_centers_x[0]), 64'd10);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_new_x0", 64'(bus.new_centers_x[0]), 64'd0);
        chk("abort_new_y0", 64'(bus.new_centers_y[0]), 64'd0);
        sbq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        launch(2);
        wait_idle("after_reset");

        // Start while busy is ignored; start the cycle after done is accepted
        @(negedge clk);
        launch(0);
        repeat (50) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_during_run", 64'(bus.busy), 64'd1);
        wait_idle("ignored_start");
        @(posedge clk);
        #1;
        launch(1);
        wait_idle("back_to_back");
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
